// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, word type and range helper for the data memory.
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int DMEM_DEPTH_DEFAULT = 64;
    typedef logic [DATA_W-1:0] word_t;
    // An address is in range when every bit above the word index is zero.
    function automatic logic dmem_in_range(input word_t addr, input int aw);
        return (addr >> (aw + 2)) == '0;
    endfunction
endpackage

// File: rtl/data_memory_if.sv
// data_memory_if: load/store bus between the datapath and the data memory.
interface data_memory_if;
    import dmem_pkg::*;
    logic  we;
    word_t A;
    word_t wd;
    word_t rd;
    modport master (output we, output A, output wd, input rd);
    modport slave (input we, input A, input wd, output rd);
endinterface

// File: rtl/dmem_addr_decode.sv
// dmem_addr_decode: splits a byte address into word index and range flag.
module dmem_addr_decode
    import dmem_pkg::*;
#(
    parameter int AW = 6
) (
    input  word_t         A,
    output logic [AW-1:0] word_idx,
    output logic          in_range
);
    // Byte offset is ignored: accesses are always word-aligned.
    logic unused_lsb;
    assign unused_lsb = ^A[1:0];
    assign in_range   = dmem_in_range(A, AW);
    assign word_idx   = A[AW+1:2];
endmodule

// File: rtl/data_memory.sv
// data_memory: word-organised memory, synchronous store, combinational load,
// async clear of all words on reset.
module data_memory
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH_DEFAULT
) (
    input logic         clk,
    input logic         rst_n,
    data_memory_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    word_t         mem_q [DEPTH];
    logic [AW-1:0] word_idx;
    logic          in_range;
    dmem_addr_decode #(.AW(AW)) u_dec (
        .A        (bus.A),
        .word_idx (word_idx),
        .in_range (in_range)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (bus.we && in_range) begin
            mem_q[word_idx] <= bus.wd;
        end
    end
    // Out-of-range reads return zero rather than aliasing a word.
    assign bus.rd = in_range ? mem_q[word_idx] : '0;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: randomized and directed checks against a word-array model.
module tb_data_memory;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0;
    int failures = 0;
    logic [31:0] model [64];
    data_memory_if bus();
    data_memory #(.DEPTH(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return (a < 32'd256) ? model[a / 4] : 32'h0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 32'h0;
    endtask

    task automatic cycle(input logic w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = w; bus.A = a; bus.wd = d;
        @(posedge clk);
        #1;
        if (w && a < 32'd256) model[a / 4] = d;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [3];
        addrs[0] = 32'd0; addrs[1] = 32'd4; addrs[2] = 32'd252;
        rst_n = 1'b0; bus.we = 1'b0; bus.A = '0; bus.wd = '0;
        clear_model();
        for (int i = 0; i < 3; i++) begin
            bus.A = addrs[i]; #1; checks++;
            if (bus.rd !== 32'h0) begin failures++; $display("FAIL reset_during A=%0h rd=%0h exp=0", addrs[i], bus.rd); end
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.A = addrs[i]; #1; checks++;
            if (bus.rd !== 32'h0) begin failures++; $display("FAIL reset_after A=%0h rd=%0h exp=0", addrs[i], bus.rd); end
        end
    endtask

    task automatic test_basic();
        cycle(1'b1, 32'd4, 32'd50);
        cycle(1'b1, 32'd8, 32'd100);
        bus.we = 1'b0;
        bus.A = 32'd4; #1; checks++;
        if (bus.rd !== 32'd50) begin failures++; $display("FAIL basic_A4 rd=%0d exp=50", bus.rd); end
        bus.A = 32'd8; #1; checks++;
        if (bus.rd !== 32'd100) begin failures++; $display("FAIL basic_A8 rd=%0d exp=100", bus.rd); end
        bus.A = 32'd12; #1; checks++;
        if (bus.rd !== 32'd0) begin failures++; $display("FAIL basic_A12 rd=%0d exp=0", bus.rd); end
    endtask

    task automatic test_disabled_alias();
        cycle(1'b0, 32'd4, 32'd7);
        checks++;
        if (bus.rd !== 32'd50) begin failures++; $display("FAIL we0_A4 rd=%0d exp=50", bus.rd); end
        for (int a = 5; a <= 7; a++) begin
            bus.A = a; #1; checks++;
            if (bus.rd !== 32'd50) begin failures++; $display("FAIL alias_A%0d rd=%0d exp=50", a, bus.rd); end
        end
    endtask

    task automatic test_same_word();
        @(negedge clk);
        bus.we = 1'b1; bus.A = 32'd8; bus.wd = 32'hDEADBEEF;
        #1; checks++;
        if (bus.rd !== 32'd100) begin failures++; $display("FAIL rw_before rd=%0h exp=64", bus.rd); end
        @(posedge clk); #1;
        model[2] = 32'hDEADBEEF;
        checks++;
        if (bus.rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rw_after rd=%0h exp=deadbeef", bus.rd); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] w0;
        w0 = model[0];
        cycle(1'b1, 32'h100, 32'd1);
        checks++;
        if (bus.rd !== 32'h0) begin failures++; $display("FAIL oor_read rd=%0h exp=0", bus.rd); end
        bus.we = 1'b0; bus.A = 32'h0; #1; checks++;
        if (bus.rd !== w0) begin failures++; $display("FAIL oor_word0 rd=%0h exp=%0h", bus.rd, w0); end
        cycle(1'b1, 32'h8000_0004, 32'h55);
        bus.we = 1'b0; bus.A = 32'd4; #1; checks++;
        if (bus.rd !== 32'd50) begin failures++; $display("FAIL oor_hi_word1 rd=%0h exp=32", bus.rd); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            logic w;
            logic [31:0] a, d, exp_old;
            w = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 255));
            d = $urandom();
            @(negedge clk);
            bus.we = w; bus.A = a; bus.wd = d;
            #1; exp_old = ref_rd(a); checks++;
            if (bus.rd !== exp_old) begin failures++; $display("FAIL rand_pre n=%0d A=%0h rd=%0h exp=%0h", n, a, bus.rd, exp_old); end
            @(posedge clk); #1;
            if (w && a < 32'd256) model[a / 4] = d;
            checks++;
            if (bus.rd !== ref_rd(a)) begin failures++; $display("FAIL rand_post n=%0d A=%0h rd=%0h exp=%0h", n, a, bus.rd, ref_rd(a)); end
        end
        @(negedge clk); bus.we = 1'b0;
        for (int i = 0; i < 64; i++) begin
            bus.A = 32'(i * 4 + $urandom_range(0, 3)); #1; checks++;
            if (bus.rd !== model[i]) begin failures++; $display("FAIL rand_sweep word=%0d rd=%0h exp=%0h", i, bus.rd, model[i]); end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 32'd4, 32'd50);
        cycle(1'b1, 32'd8, 32'hDEADBEEF);
        bus.we = 1'b0; #1; checks++;
        if (bus.rd !== 32'hDEADBEEF) begin failures++; $display("FAIL pre_reset rd=%0h exp=deadbeef", bus.rd); end
        #2 rst_n = 1'b0;
        #1; checks++;
        if (bus.rd !== 32'h0) begin failures++; $display("FAIL mid_reset rd=%0h exp=0", bus.rd); end
        bus.we = 1'b1; bus.wd = 32'd123;
        @(posedge clk); #1; checks++;
        if (bus.rd !== 32'h0) begin failures++; $display("FAIL write_in_reset rd=%0h exp=0", bus.rd); end
        @(negedge clk); bus.we = 1'b0; rst_n = 1'b1;
        clear_model();
        bus.A = 32'd4; #1; checks++;
        if (bus.rd !== 32'h0) begin failures++; $display("FAIL post_reset_A4 rd=%0h exp=0", bus.rd); end
        bus.A = 32'd8; #1; checks++;
        if (bus.rd !== 32'h0) begin failures++; $display("FAIL post_reset_A8 rd=%0h exp=0", bus.rd); end
        cycle(1'b1, 32'd252, 32'h1234_5678);
        checks++;
        if (bus.rd !== 32'h1234_5678) begin failures++; $display("FAIL post_reset_write rd=%0h exp=12345678", bus.rd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_disabled_alias();
        test_same_word();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_memory.md
# data_memory

Word-organised data memory for the single-cycle datapath, serving the load/store stage. It holds a parameterised number of 32-bit words. Stores happen synchronously on the rising clock edge and loads are combinational from the byte address. An asynchronous active-low reset clears every word to zero.

## Interface
Parameters:
- `DEPTH`, default 64: number of 32-bit words; must be a power of two, at least 4.
- `AW`, default `$clog2(DEPTH)`: word-index width, derived (not overridden).

Ports:
- `clk`, input, 1: single clock; all writes occur on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset. Clears all storage immediately on assertion.
- `we`, input, 1: write enable, sampled at the rising edge of `clk`.
- `A`, input, 32: byte address; word index is `A[AW+1:2]`.
- `wd`, input, 32: write data.
- `rd`, output, 32: read data, combinational from `A` and the array contents.

## Operation
- Storage: array of `DEPTH` × 32-bit registers.
- Addressing:
  - `A[1:0]` ignored; accesses are always word-aligned.
  - `A[AW+1:2]` selects the word.
- Range check: an address is in range when `A[31:AW+2] == 0`.
- Write: at the rising `clk` with `we=1`, `rst_n=1` and `A` in range, `mem[A[AW+1:2]] <= wd`.
  - `we=1` with an out-of-range `A` is ignored; no word changes and no wrap-around.
  - `we=0` leaves storage unchanged.
- Read: `rd = mem[A[AW+1:2]]` when `A` is in range; otherwise `rd = 32'h0`. The read port is independent of `we`.
- Reset:
  - `rst_n=0` forces every word to 0 asynchronously, so `rd = 0` for all addresses.
  - Writes are blocked while `rst_n=0`.
  - After release, storage stays all-zero until the first write.
- Misaligned addresses: `A=4`, `5`, `6` and `7` all alias word 1.

## Timing
- Write latency: 1 edge. New data is visible on `rd` right after the capturing rising edge, within the same delta/cycle when `A` still points at that word.
- Read latency: 0 cycles (combinational). `rd` follows changes in `A` with no clock.
- Read and write to the same word in one cycle: before the edge `rd` shows the old contents; after the edge it shows `wd`. No bypass.
- Reset asserted mid-cycle, including coincident with a write edge: reset wins and the word ends at 0.
- Reset deasserted at a write edge: that edge's write is not guaranteed and the bench must not rely on it. Writes are guaranteed from the next edge.
- `rd` value during reset: 0.

## Structure
- Shared package `dmem_pkg`:
  - `DATA_W = 32`
  - `DMEM_DEPTH_DEFAULT = 64`
  - typedef `word_t` (32-bit logic)
  - function `dmem_in_range(addr, aw)`
- One sub-module, `dmem_addr_decode`:
  - Input: `A`. Outputs: `word_idx[AW-1:0]` and `in_range`.
  - Shared by the read and write paths.
- Top level `data_memory`: register array with an async-reset clear loop, write-enable gating, and the read mux with zero fill for out-of-range addresses.

## Test plan
- Reset then read: pulse `rst_n=0`, release, read `A=0`, 4, 252 → `rd=0` for each.
- Basic writes and reads back:
  - Writes: `we=1,A=4,wd=50` at edge 1; `we=1,A=8,wd=100` at edge 2.
  - Reads with `we=0`: `A=4` → `rd=50` immediately; `A=8` → `rd=100`; `A=12` → `rd=0`.
- Disabled write and aliasing:
  - `we=0,A=4,wd=7` at an edge → `rd` at `A=4` stays 50.
  - `A=6` → `rd=50`.
- Same-word read and write in one cycle: hold `A=8`, `we=1`, `wd=32'hDEADBEEF` → `rd=100` before the edge, `32'hDEADBEEF` after the edge.
- Out-of-range write ignored: `we=1`, `A=32'h100`, `wd=1` with `DEPTH=64` → `rd=0` at that address; word 0 is unchanged.
- Reset mid-operation: after the writes above, assert `rst_n=0` between edges → `rd` drops to 0 at once. After release, `A=4` and `A=8` both read 0.
